// File: rtl/pio_multi_ch_if.sv
// Register bus for pio_multi_ch: word address, write/read strobes, 32-bit data.
// No waitrequest; readdata follows a read by exactly one cycle.
interface pio_multi_ch_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/pio_multi_ch.sv
// Multi-channel PIO: output register with set/clear, synchronised input with
// edge capture and interrupt, and a retriggerable output pulse sequencer.
//
//   state  | meaning
//   IDLE   | no pulse running, pulse_mask == 0
//   ACTIVE | pulse running, cnt counts down to expiry, pulse_mask != 0
module pio_multi_ch #(
  parameter int                    DATA_WIDTH  = 2,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                  clk_100_clk,
  input  logic                  reset_reset_n,
  pio_multi_ch_if.slave         bus,
  output logic [DATA_WIDTH-1:0] out_port,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   cap_q, cap_d;
  logic [DATA_WIDTH-1:0]   pmask_q, pmask_d;
  logic [15:0]             plen_q, plen_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    irq_q;
  logic [31:0]             rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]   dly_q;

  logic [DATA_WIDTH-1:0]   wd, in_sync, edge_det;
  logic [15:0]             plen_eff;
  logic                    wr_out, wr_mask, wr_cap, wr_set, wr_clr, wr_plen, pulse_wr;
  logic                    expire;
  logic                    unused_wd;

  assign wd       = bus.writedata[DATA_WIDTH-1:0];
  assign wr_out   = bus.write && (bus.address == 3'd0);
  assign wr_mask  = bus.write && (bus.address == 3'd2);
  assign wr_cap   = bus.write && (bus.address == 3'd3);
  assign wr_set   = bus.write && (bus.address == 3'd4);
  assign wr_clr   = bus.write && (bus.address == 3'd5);
  assign wr_plen  = bus.write && (bus.address == 3'd6);
  assign pulse_wr = bus.write && (bus.address == 3'd7) && (wd != '0);
  assign plen_eff = (plen_q == 16'd0) ? 16'd1 : plen_q;
  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign unused_wd = ^bus.writedata[31:16];

  // Input synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= in_sync;
    end
  end

  // Edge select: rising, falling or any.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~dly_q;
      1:       edge_det = ~in_sync & dly_q;
      default: edge_det = in_sync ^ dly_q;
    endcase
  end

  // Pulse sequencer: load/retrigger on a non-zero PULSE write, expire at cnt==1.
  always_comb begin
    state_d = state_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_wr) begin
          state_d = ACTIVE;
          pmask_d = wd;
          cnt_d   = plen_eff;
        end
      end
      ACTIVE: begin
        if (pulse_wr) begin
          pmask_d = pmask_q | wd;
          cnt_d   = plen_eff;
        end else if (cnt_q == 16'd1) begin
          expire  = 1'b1;
          pmask_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register next-state: expiry clear lands first so a same-cycle CPU write wins;
  // edge capture is applied after W1C so a new edge keeps the bit set.
  always_comb begin
    out_d = out_q;
    if (expire)   out_d = out_d & ~pmask_q;
    if (wr_out)   out_d = wd;
    if (wr_set)   out_d = out_d | wd;
    if (wr_clr)   out_d = out_d & ~wd;
    if (pulse_wr) out_d = out_d | wd;

    mask_d = wr_mask ? wd : mask_q;
    plen_d = wr_plen ? bus.writedata[15:0] : plen_q;

    cap_d = cap_q;
    if (wr_cap) cap_d = cap_d & ~wd;
    cap_d = cap_d | edge_det;
  end

  // Read mux; unused upper bits and write-only addresses read as zero.
  always_comb begin
    rd_d = rd_q;
    if (bus.read) begin
      rd_d = '0;
      case (bus.address)
        3'd0:    rd_d[DATA_WIDTH-1:0] = out_q;
        3'd1:    rd_d[DATA_WIDTH-1:0] = in_sync;
        3'd2:    rd_d[DATA_WIDTH-1:0] = mask_q;
        3'd3:    rd_d[DATA_WIDTH-1:0] = cap_q;
        3'd6:    rd_d[15:0]           = plen_q;
        3'd7:    rd_d[DATA_WIDTH-1:0] = pmask_q;
        default: rd_d = '0;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      out_q   <= OUT_RESET;
      mask_q  <= '0;
      cap_q   <= '0;
      pmask_q <= '0;
      plen_q  <= 16'd1;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      pmask_q <= pmask_d;
      plen_q  <= plen_d;
      cnt_q   <= cnt_d;
      irq_q   <= |(cap_q & mask_q);
      rd_q    <= rd_d;
    end
  end

  assign out_port     = out_q;
  assign irq          = irq_q;
  assign bus.readdata = rd_q;

endmodule

// File: tb/tb_pio_multi_ch.sv
// Scoreboarded bench for pio_multi_ch with DATA_WIDTH=2, SYNC_STAGES=2,
// rising-edge capture and OUT_RESET=2'b10.
module tb_pio_multi_ch;
  localparam int              DW   = 2;
  localparam int              SYNC = 2;
  localparam logic [DW-1:0]   ORST = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] out_port;
  logic [DW-1:0] in_port;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;
  int hi0    = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  pio_multi_ch_if bus ();

  pio_multi_ch #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SYNC),
    .EDGE_TYPE  (0),
    .OUT_RESET  (ORST)
  ) dut (
    .clk_100_clk  (clk),
    .reset_reset_n(rst_n),
    .bus          (bus.slave),
    .out_port     (out_port),
    .in_port      (in_port),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Counts cycles during which out_port[0] is high.
  always @(negedge clk) if (out_port[0]) hi0++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus.address = a; bus.read = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    bus.read = 1'b0;
    chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
  endtask

  task automatic wait_out0_low(input string tag);
    int k;
    k = 0;
    while (out_port[0] && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_port = '0;
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out_port), 32'(ORST));
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd", bus.readdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(3'd2, 32'd0, "rst_mask");
    bus_read(3'd3, 32'd0, "rst_cap");
    bus_read(3'd6, 32'd1, "rst_plen");
    bus_read(3'd7, 32'd0, "rst_pmask");

    // OUT, OUTCLR, OUTSET and readback
    bus_write(3'd0, 32'd3);
    chk("out_wr", 32'(out_port), 32'd3);
    bus_write(3'd5, 32'd1);
    chk("out_clr", 32'(out_port), 32'd2);
    bus_read(3'd0, 32'd2, "rd_out");
    bus_write(3'd4, 32'd1);
    chk("out_set", 32'(out_port), 32'd3);
    bus_read(3'd4, 32'd0, "rd_wo4");
    bus_read(3'd5, 32'd0, "rd_wo5");
    bus_write(3'd0, 32'hFFFF_FFFC);
    bus_read(3'd0, 32'd0, "rd_out_upper");

    // IN path and unmasked capture
    in_port = 2'b10;
    repeat (4) @(negedge clk);
    bus_read(3'd1, 32'd2, "rd_in");
    chk("irq_masked", 32'(irq), 32'd0);
    bus_read(3'd3, 32'd2, "cap_b1");
    bus_write(3'd3, 32'd2);
    bus_read(3'd3, 32'd0, "cap_w1c");

    // Masked edge raises irq within SYNC+2 cycles; W1C drops it
    bus_write(3'd2, 32'd1);
    in_port[0] = 1'b1;
    k = 0;
    while (!irq && k < SYNC + 2) begin @(negedge clk); k++; end
    chk("irq_rise", 32'(irq), 32'd1);
    bus_read(3'd3, 32'd1, "cap_b0");
    bus_write(3'd3, 32'd1);
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'd0);
    in_port[0] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd3, 32'd0, "no_fall_cap");

    // 5-cycle pulse on bit 0, bit 1 untouched
    bus_write(3'd0, 32'd2);
    bus_write(3'd6, 32'd5);
    hi0 = 0;
    bus_write(3'd7, 32'd1);
    chk("pulse_on", 32'(out_port), 32'd3);
    wait_out0_low("p5");
    chk("pulse5_w", 32'(hi0), 32'd5);
    chk("pulse5_out", 32'(out_port), 32'd2);

    // PULSE write of zero is ignored
    bus_write(3'd7, 32'd0);
    bus_read(3'd7, 32'd0, "pulse_zero");

    // PULSE_LEN=0 gives a one-cycle pulse
    bus_write(3'd6, 32'd0);
    hi0 = 0;
    bus_write(3'd7, 32'd1);
    wait_out0_low("p0");
    chk("pulse0_w", 32'(hi0), 32'd1);

    // Retrigger at cycle 3 of a 5-cycle pulse -> 8 cycles; masks OR
    bus_write(3'd6, 32'd5);
    hi0 = 0;
    bus_write(3'd7, 32'd1);
    repeat (2) @(negedge clk);
    bus_write(3'd7, 32'd2);
    bus_read(3'd7, 32'd3, "retrig_mask");
    wait_out0_low("p8");
    chk("retrig_w", 32'(hi0), 32'd8);
    chk("retrig_out", 32'(out_port), 32'd0);

    // OUTSET coinciding with expiry: CPU value wins
    bus_write(3'd6, 32'd3);
    bus_write(3'd7, 32'd1);
    repeat (2) @(negedge clk);
    bus_write(3'd4, 32'd1);
    chk("exp_vs_set", 32'(out_port), 32'd1);
    bus_read(3'd7, 32'd0, "exp_pmask");
    bus_write(3'd5, 32'd3);

    // Edge and W1C on bit 0 in the same cycle: set wins
    in_port[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(3'd3, 32'd1);
    bus_read(3'd3, 32'd1, "set_prio");
    bus_write(3'd3, 32'd1);

    // Reset mid-pulse: async return to OUT_RESET, no resume
    in_port = '0;
    bus_write(3'd6, 32'd10);
    bus_write(3'd7, 32'd1);
    @(negedge clk);
    chk("mid_pulse", 32'(out_port), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", 32'(out_port), 32'(ORST));
    chk("async_rst_rd", bus.readdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi0 = 0;
    repeat (15) @(negedge clk);
    chk("no_resume_w", 32'(hi0), 32'd0);
    chk("no_resume_out", 32'(out_port), 32'(ORST));
    bus_read(3'd7, 32'd0, "post_rst_pmask");
    bus_read(3'd3, 32'd0, "no_false_edge");
    bus_read(3'd6, 32'd1, "post_rst_plen");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
